// File: rtl/sfixed_fifo_drain.sv
// Drains an accumulating fifo one word at a time, adds a bias, applies an
// optional ReLU, rescales to a narrower signed fixed-point format with
// saturation and hands each word downstream over a valid/ready handshake.
module sfixed_fifo_drain #(
  parameter int unsigned INT_WIDTH      = 16,
  parameter int unsigned FRAC_WIDTH     = 16,
  parameter int unsigned FIFO_DEPTH     = 128,
  parameter int unsigned OUT_INT_WIDTH  = 8,
  parameter int unsigned OUT_FRAC_WIDTH = 8,
  parameter bit          RELU_EN        = 1'b1
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    start,
  input  logic                                    layer_nr,
  input  logic [INT_WIDTH+FRAC_WIDTH-1:0]         bias,
  input  logic [INT_WIDTH+FRAC_WIDTH-1:0]         fifo_data,
  output logic                                    fifo_write_en,
  output logic [INT_WIDTH+FRAC_WIDTH-1:0]         fifo_data_in,
  output logic                                    m_valid,
  input  logic                                    m_ready,
  output logic [OUT_INT_WIDTH+OUT_FRAC_WIDTH-1:0] m_data,
  output logic                                    busy,
  output logic                                    done
);

  localparam int unsigned W          = INT_WIDTH + FRAC_WIDTH;
  localparam int unsigned OW         = OUT_INT_WIDTH + OUT_FRAC_WIDTH;
  localparam int unsigned Shift      = FRAC_WIDTH - OUT_FRAC_WIDTH;
  localparam int unsigned SmallDepth = 25;
  localparam int unsigned MaxDepth   = (FIFO_DEPTH > SmallDepth) ? FIFO_DEPTH : SmallDepth;
  localparam int unsigned CntW       = $clog2(MaxDepth + 1);

  // Saturation bounds of the output format, sign-extended to the sum width.
  localparam logic signed [W:0] OutMax = {{(W + 2 - OW){1'b0}}, {(OW - 1){1'b1}}};
  localparam logic signed [W:0] OutMin = {{(W + 2 - OW){1'b1}}, {(OW - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StFetch, StSend, StFinish} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] depth_q, depth_d;
  logic [W-1:0]    bias_q, bias_d;
  logic [OW-1:0]   data_q, data_d;

  logic signed [W:0] sum;
  logic signed [W:0] relu_sum;
  logic signed [W:0] shifted;
  logic [OW-1:0]     sat;

  // Datapath: bias add, optional ReLU, floor rescale, saturate.
  always_comb begin
    sum      = $signed({fifo_data[W-1], fifo_data}) + $signed({bias_q[W-1], bias_q});
    relu_sum = (RELU_EN && sum[W]) ? '0 : sum;
    shifted  = relu_sum >>> Shift;
    if (shifted > OutMax) begin
      sat = OutMax[OW-1:0];
    end else if (shifted < OutMin) begin
      sat = OutMin[OW-1:0];
    end else begin
      sat = shifted[OW-1:0];
    end
  end

  // Next-state logic for the drain sequencer and its registers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    depth_d = depth_q;
    bias_d  = bias_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          depth_d = layer_nr ? CntW'(FIFO_DEPTH) : CntW'(SmallDepth);
          bias_d  = bias;
          cnt_d   = '0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        // The fifo steps its index on this same edge, so capture the word now.
        data_d  = sat;
        cnt_d   = cnt_q + CntW'(1);
        state_d = StSend;
      end
      StSend: begin
        if (m_ready) begin
          state_d = (cnt_q == depth_q) ? StFinish : StFetch;
        end
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      depth_q <= CntW'(SmallDepth);
      bias_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      depth_q <= depth_d;
      bias_q  <= bias_d;
      data_q  <= data_d;
    end
  end

  // Writing zero back keeps the accumulated fifo contents intact (x + 0).
  assign fifo_data_in  = '0;
  assign fifo_write_en = (state_q == StFetch);
  assign m_valid       = (state_q == StSend);
  assign m_data        = data_q;
  assign busy          = (state_q != StIdle);
  assign done          = (state_q == StFinish);

endmodule

// File: tb/tb_sfixed_fifo_drain.sv
// Directed bench for sfixed_fifo_drain with an accumulating-fifo model and a
// scoreboard of expected output words.
module tb_sfixed_fifo_drain;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        layer_nr = 1'b0;
  logic        m_ready = 1'b0;
  logic [31:0] bias = '0;
  logic [31:0] fifo_data;

  logic        fifo_write_en, fifo_write_en_nr;
  logic [31:0] fifo_data_in, fifo_data_in_nr;
  logic        m_valid, m_valid_nr;
  logic [15:0] m_data, m_data_nr;
  logic        busy, busy_nr, done, done_nr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sfixed_fifo_drain #(.RELU_EN(1'b1)) u_dut (
    .clk(clk), .reset(reset), .start(start), .layer_nr(layer_nr), .bias(bias),
    .fifo_data(fifo_data), .fifo_write_en(fifo_write_en), .fifo_data_in(fifo_data_in),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy), .done(done)
  );

  sfixed_fifo_drain #(.RELU_EN(1'b0)) u_dut_norelu (
    .clk(clk), .reset(reset), .start(start), .layer_nr(layer_nr), .bias(bias),
    .fifo_data(fifo_data), .fifo_write_en(fifo_write_en_nr), .fifo_data_in(fifo_data_in_nr),
    .m_valid(m_valid_nr), .m_ready(m_ready), .m_data(m_data_nr), .busy(busy_nr),
    .done(done_nr)
  );

  // Accumulating fifo model: index steps on write_en and wraps at len.
  logic [31:0] mem [128];
  logic [31:0] pre [128];
  int unsigned idx = 0;
  int unsigned len = 25;
  int unsigned pre_len = 25;
  logic        load = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx <= 0;
    end else if (load) begin
      for (int i = 0; i < 128; i++) mem[i] <= pre[i];
      idx <= 0;
      len <= pre_len;
    end else if (fifo_write_en) begin
      mem[idx] <= mem[idx] + fifo_data_in;
      idx      <= (idx + 1 == len) ? 0 : idx + 1;
    end
  end

  assign fifo_data = mem[idx];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: bias add, optional ReLU, floor divide by 256, clamp to 16 bits.
  function automatic logic [15:0] model(input logic [31:0] w, input logic [31:0] b,
                                        input bit relu);
    longint s;
    s = longint'($signed(w)) + longint'($signed(b));
    if (relu && s < 0) s = 0;
    s = s >>> 8;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s[15:0];
  endfunction

  // Scoreboard monitor, sampled on the falling edge.
  logic [15:0] exp_q[$];
  logic [15:0] exp_nr_q[$];
  logic [15:0] got_q[$];
  logic [15:0] got_nr_q[$];
  int word_cnt = 0;
  int done_cnt = 0;
  int wen_cnt = 0;

  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      exp_nr_q.delete();
    end else begin
      if (fifo_write_en) begin
        exp_q.push_back(model(fifo_data, bias, 1'b1));
        exp_nr_q.push_back(model(fifo_data, bias, 1'b0));
        wen_cnt++;
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_empty", 64'(exp_q.size()), 64'd1);
        end else begin
          check("m_data", m_data, exp_q.pop_front());
          check("m_data_norelu", m_data_nr, exp_nr_q.pop_front());
        end
        got_q.push_back(m_data);
        got_nr_q.push_back(m_data_nr);
        word_cnt++;
      end
      if (done) done_cnt++;
    end
  end

  int w0, d0, e0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_fifo(input int unsigned n);
    pre_len = n;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic snap();
    w0 = word_cnt;
    d0 = done_cnt;
    e0 = wen_cnt;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (done_cnt == d0 && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_done_seen"}, 64'(done_cnt != d0), 64'd1);
    repeat (3) tick();
  endtask

  task automatic drain_summary(input string tag, input int words);
    check({tag, "_words"}, 64'(word_cnt - w0), 64'(words));
    check({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
    check({tag, "_wen_pulses"}, 64'(wen_cnt - e0), 64'(words));
    check({tag, "_fifo_idx"}, 64'(idx), 64'd0);
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [15:0] exp0;
    int k;

    // Reset state
    reset = 1'b0;
    repeat (2) tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_m_data", 64'(m_data), 64'd0);
    check("rst_write_en", 64'(fifo_write_en), 64'd0);
    check("rst_data_in", 64'(fifo_data_in), 64'd0);
    reset = 1'b1;
    tick();

    // Depth-25 drain of 1.0..25.0 with zero bias
    for (int i = 0; i < 128; i++) pre[i] = 32'(i + 1) << 16;
    load_fifo(25);
    bias = 32'h0;
    layer_nr = 1'b0;
    m_ready = 1'b1;
    snap();
    pulse_start();
    check("a_write_en_fetch", 64'(fifo_write_en), 64'd1);
    wait_done("a", 200);
    drain_summary("a", 25);
    if (got_q.size() >= w0 + 25) begin
      check("a_first_word", 64'(got_q[w0]), 64'h0100);
      check("a_last_word", 64'(got_q[w0 + 24]), 64'h1900);
    end

    // ReLU and saturation corners with bias 1.0
    for (int i = 0; i < 128; i++) pre[i] = $urandom;
    pre[0] = 32'hFFFD_0000;
    pre[1] = 32'h00C8_0000;
    pre[2] = 32'hFF38_0000;
    load_fifo(25);
    bias = 32'h0001_0000;
    snap();
    pulse_start();
    wait_done("b", 200);
    drain_summary("b", 25);
    if (got_q.size() >= w0 + 3) begin
      check("b_relu_neg", 64'(got_q[w0]), 64'h0000);
      check("b_norelu_neg", 64'(got_nr_q[w0]), 64'hFE00);
      check("b_sat_pos", 64'(got_nr_q[w0 + 1]), 64'h7FFF);
      check("b_sat_neg", 64'(got_nr_q[w0 + 2]), 64'h8000);
      check("b_relu_sat_neg", 64'(got_q[w0 + 2]), 64'h0000);
    end

    // Back-pressure: m_ready low for 10 cycles on the first word
    for (int i = 0; i < 128; i++) pre[i] = $urandom_range(32'h0100_0000, 0) - 32'h0080_0000;
    load_fifo(25);
    bias = 32'hFFFF_8000;
    m_ready = 1'b0;
    snap();
    pulse_start();
    k = 0;
    while (!m_valid && k < 10) begin
      tick();
      k++;
    end
    check("c_valid_seen", 64'(m_valid), 64'd1);
    exp0 = model(pre[0], bias, 1'b1);
    e0 = wen_cnt;
    repeat (10) begin
      tick();
      check("c_stall_valid", 64'(m_valid), 64'd1);
      check("c_stall_data", 64'(m_data), 64'(exp0));
    end
    check("c_stall_no_wen", 64'(wen_cnt - e0), 64'd0);
    m_ready = 1'b1;
    e0 = e0 - 1;
    wait_done("c", 200);
    drain_summary("c", 25);

    // Full-depth drain with a second start ignored mid-drain
    for (int i = 0; i < 128; i++) pre[i] = $urandom;
    load_fifo(128);
    bias = 32'h0000_0100;
    layer_nr = 1'b1;
    snap();
    pulse_start();
    repeat (20) tick();
    layer_nr = 1'b0;
    pulse_start();
    layer_nr = 1'b1;
    wait_done("d", 1000);
    drain_summary("d", 128);

    // Asynchronous reset at word 7
    for (int i = 0; i < 128; i++) pre[i] = $urandom;
    load_fifo(25);
    layer_nr = 1'b0;
    snap();
    pulse_start();
    k = 0;
    while (word_cnt - w0 < 7 && k < 100) begin
      tick();
      k++;
    end
    check("e_reached_word7", 64'(word_cnt - w0 >= 7), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("e_async_valid", 64'(m_valid), 64'd0);
    check("e_async_busy", 64'(busy), 64'd0);
    check("e_async_wen", 64'(fifo_write_en), 64'd0);
    repeat (2) tick();
    reset = 1'b1;
    repeat (5) tick();
    check("e_no_done", 64'(done_cnt - d0), 64'd0);
    check("e_idle_busy", 64'(busy), 64'd0);
    check("e_idle_valid", 64'(m_valid), 64'd0);
    check("e_idle_m_data", 64'(m_data), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
